// File: rtl/uart_tx_fifo_bridge.sv
// Circular FIFO between a byte producer and the UART transmitter.
// Words leave one at a time once a drain is triggered (threshold, flush or idle timeout).
module uart_tx_fifo_bridge #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int BURST_THRESH = 1,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_dv,
  input  logic [DATA_W-1:0]          in_byte,
  input  logic                       flush,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       tx_dv,
  output logic [DATA_W-1:0]          tx_byte,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [TMR_W-1:0]  idle_timer;
  logic              draining;
  logic              timer_expired;
  logic              drain_req;
  logic              pop;
  logic              wr_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // The trigger terms are folded in combinationally so a pop can happen on the
  // same edge that would otherwise only set the draining latch.
  assign timer_expired = (IDLE_TIMEOUT != 0) && (idle_timer == TMR_W'(IDLE_TIMEOUT));
  assign drain_req     = draining || (count >= CNT_W'(BURST_THRESH)) ||
                         (flush && !empty) || timer_expired;
  assign wr_en         = in_dv && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop)     state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state == IDLE) pop = drain_req && !empty && !tx_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      draining   <= 1'b0;
      idle_timer <= '0;
      overflow   <= 1'b0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
    end else begin
      tx_dv <= pop;
      if (pop) begin
        tx_byte <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      else if (in_dv) overflow <= 1'b1;

      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Only a pop that really empties the FIFO ends the drain.
      if (pop && !wr_en && count == CNT_W'(1)) draining <= 1'b0;
      else                                     draining <= drain_req;

      if (wr_en || empty) idle_timer <= '0;
      else if (idle_timer != TMR_W'(IDLE_TIMEOUT)) idle_timer <= idle_timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_byte;
  end

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// Self-checking bench: stream-mode instance checked against a queue model under
// directed and random traffic, plus a burst/timeout instance with directed checks.
module tb_uart_tx_fifo_bridge;

  localparam int A_DEPTH  = 4;
  localparam int A_THRESH = 1;
  localparam int A_TOUT   = 0;

  logic       clk = 1'b0;
  logic       rst, in_dv, flush, tx_busy, tx_done;
  logic [7:0] in_byte;
  logic       tx_dv, full, empty, overflow;
  logic [7:0] tx_byte;
  logic [2:0] count;

  logic       b_rst, b_in_dv, b_flush, b_tx_busy, b_tx_done;
  logic [7:0] b_in_byte;
  logic       b_tx_dv, b_full, b_empty, b_overflow;
  logic [7:0] b_tx_byte;
  logic [2:0] b_count;

  int tests_run = 0;
  int tests_failed = 0;

  uart_tx_fifo_bridge #(.DATA_W(8), .DEPTH(A_DEPTH), .BURST_THRESH(A_THRESH), .IDLE_TIMEOUT(A_TOUT)) dut_a (
    .clk(clk), .rst(rst), .in_dv(in_dv), .in_byte(in_byte), .flush(flush),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  uart_tx_fifo_bridge #(.DATA_W(8), .DEPTH(4), .BURST_THRESH(4), .IDLE_TIMEOUT(20)) dut_b (
    .clk(clk), .rst(b_rst), .in_dv(b_in_dv), .in_byte(b_in_byte), .flush(b_flush),
    .tx_busy(b_tx_busy), .tx_done(b_tx_done), .tx_dv(b_tx_dv), .tx_byte(b_tx_byte),
    .count(b_count), .full(b_full), .empty(b_empty), .overflow(b_overflow)
  );

  always #5 clk = ~clk;

  // Reference model of the stream-mode instance: a byte queue plus the drain rules.
  logic [7:0] mq[$];
  bit         m_drain, m_wait, m_ovf, m_dv;
  logic [7:0] m_byte;
  int         m_timer;

  int         uart_cnt, uart_min, uart_max;
  bit         hold_busy, rand_busy, spurious_en;
  logic [7:0] got_q[$];

  int         b_uart_cnt, b_cyc;
  logic [7:0] b_got[$];
  int         b_dv_cyc[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit dv, input logic [7:0] b, input bit fl, input bit rs);
    bit drain, pop, acc, was_empty;
    in_dv = dv; in_byte = b; flush = fl; rst = rs;
    tx_done = 1'b0;
    if (uart_cnt > 1) begin
      tx_busy = 1'b1; uart_cnt--;
    end else if (uart_cnt == 1) begin
      tx_busy = 1'b0; tx_done = 1'b1; uart_cnt = 0;
    end else begin
      tx_busy = rand_busy && ($urandom_range(0, 4) == 0);
      tx_done = spurious_en && ($urandom_range(0, 19) == 0);
    end
    if (hold_busy) tx_busy = 1'b1;

    if (rs) begin
      mq.delete(); m_drain = 0; m_wait = 0; m_ovf = 0; m_dv = 0; m_byte = 8'h00; m_timer = 0;
    end else begin
      was_empty = (mq.size() == 0);
      drain = m_drain || (mq.size() >= A_THRESH) || (fl && !was_empty) ||
              (A_TOUT != 0 && m_timer == A_TOUT);
      pop = !m_wait && drain && !was_empty && !tx_busy;
      acc = dv && (mq.size() < A_DEPTH || pop);
      if (pop) begin
        m_byte = mq.pop_front(); m_dv = 1; m_wait = 1;
      end else begin
        m_dv = 0;
        if (m_wait && tx_done) m_wait = 0;
      end
      if (acc) mq.push_back(b);
      else if (dv) m_ovf = 1;
      if (pop && mq.size() == 0) m_drain = 0;
      else if (drain) m_drain = 1;
      if (acc || was_empty) m_timer = 0;
      else if (m_timer < A_TOUT) m_timer++;
    end

    @(posedge clk); #1;
    checkOutput("tx_dv", 32'(tx_dv), 32'(m_dv));
    checkOutput("tx_byte", 32'(tx_byte), 32'(m_byte));
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("full", 32'(full), 32'(mq.size() == A_DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (tx_dv === 1'b1) begin
      got_q.push_back(tx_byte);
      uart_cnt = $urandom_range(uart_min, uart_max);
    end
  endtask

  task automatic drainA();
    int n = 0;
    while ((mq.size() > 0 || m_wait || uart_cnt > 0) && n < 300) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    checkOutput("drain_bound_expired", 32'(n >= 300), 32'd0);
  endtask

  task automatic stepB(input bit dv, input logic [7:0] b, input bit fl, input bit rs);
    b_in_dv = dv; b_in_byte = b; b_flush = fl; b_rst = rs;
    b_tx_busy = 1'b0; b_tx_done = 1'b0;
    if (b_uart_cnt > 1) begin
      b_tx_busy = 1'b1; b_uart_cnt--;
    end else if (b_uart_cnt == 1) begin
      b_tx_done = 1'b1; b_uart_cnt = 0;
    end
    @(posedge clk); #1;
    b_cyc++;
    if (b_tx_dv === 1'b1) begin
      b_got.push_back(b_tx_byte);
      b_dv_cyc.push_back(b_cyc);
      b_uart_cnt = 3;
    end
  endtask

  task automatic waitB(input int want);
    int n = 0;
    while ((b_got.size() < want || b_uart_cnt > 0) && n < 100) begin
      stepB(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    checkOutput("b_wait_bound_expired", 32'(n >= 100), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lcyc, fcyc;
    rst = 1; in_dv = 0; in_byte = 0; flush = 0; tx_busy = 0; tx_done = 0;
    b_rst = 1; b_in_dv = 0; b_in_byte = 0; b_flush = 0; b_tx_busy = 0; b_tx_done = 0;
    uart_cnt = 0; uart_min = 10; uart_max = 10;
    hold_busy = 0; rand_busy = 0; spurious_en = 0; b_uart_cnt = 0; b_cyc = 0;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_tx_dv", 32'(tx_dv), 32'd0);
    checkOutput("rst_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);

    // Stream: write at N, tx_dv at N+2
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("stream_count_n1", 32'(count), 32'd1);
    checkOutput("stream_empty_n1", 32'(empty), 32'd0);
    checkOutput("stream_no_dv_n1", 32'(tx_dv), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("stream_dv_n2", 32'(tx_dv), 32'd1);
    checkOutput("stream_byte_n2", 32'(tx_byte), 32'hA5);
    drainA();
    checkOutput("stream_count_end", 32'(count), 32'd0);
    checkOutput("stream_empty_end", 32'(empty), 32'd1);

    // Ordering and pointer wrap
    uart_min = 1; uart_max = 5;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    got_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      hold_busy = 1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(pass * 4 + i + 1), 1'b0, 1'b0);
      checkOutput("wrap_full", 32'(full), 32'd1);
      hold_busy = 0;
      drainA();
    end
    checkOutput("wrap_n_bytes", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) checkOutput("wrap_order", 32'(got_q[i]), 32'(i + 1));
    checkOutput("wrap_no_overflow", 32'(overflow), 32'd0);

    // Overflow with UART busy
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    got_q.delete();
    hold_busy = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    checkOutput("ovf_full_after_4", 32'(full), 32'd1);
    checkOutput("ovf_clear_after_4", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'h14, 1'b0, 1'b0);
    checkOutput("ovf_set_after_5", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd4);
    hold_busy = 0;
    drainA();
    checkOutput("ovf_n_bytes", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) checkOutput("ovf_data", 32'(got_q[i]), 32'(8'h10 + i));
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Write into a full FIFO in the exact pop cycle
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    got_q.delete();
    hold_busy = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    hold_busy = 0;
    applyStimulus(1'b1, 8'h24, 1'b0, 1'b0);
    checkOutput("simul_dv", 32'(tx_dv), 32'd1);
    checkOutput("simul_byte", 32'(tx_byte), 32'h20);
    checkOutput("simul_count", 32'(count), 32'd4);
    checkOutput("simul_no_overflow", 32'(overflow), 32'd0);
    drainA();
    checkOutput("simul_n_bytes", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) checkOutput("simul_data", 32'(got_q[i]), 32'(8'h20 + i));

    // Reset while waiting for tx_done with 3 words queued
    uart_min = 10; uart_max = 10;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    hold_busy = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    hold_busy = 0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midrst_dv", 32'(tx_dv), 32'd1);
    checkOutput("midrst_queued", 32'(count), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_tx_dv", 32'(tx_dv), 32'd0);
    got_q.delete();
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midrst_no_dv_after_done", 32'(got_q.size()), 32'd0);

    // Random traffic against the model
    uart_min = 1; uart_max = 6; rand_busy = 1; spurious_en = 1;
    for (int i = 0; i < 600; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 199) == 0));
    rand_busy = 0; spurious_en = 0;
    drainA();

    // Burst threshold, flush and idle timeout on the second instance
    stepB(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("b_rst_count", 32'(b_count), 32'd0);
    checkOutput("b_rst_empty", 32'(b_empty), 32'd1);
    b_got.delete(); b_dv_cyc.delete();
    for (int i = 0; i < 3; i++) stepB(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) stepB(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("b_below_thresh_no_dv", 32'(b_got.size()), 32'd0);
    checkOutput("b_below_thresh_count", 32'(b_count), 32'd3);
    stepB(1'b0, 8'h00, 1'b1, 1'b0);
    fcyc = b_cyc;
    waitB(3);
    checkOutput("b_flush_n_bytes", 32'(b_got.size()), 32'd3);
    for (int i = 0; i < 3 && i < b_got.size(); i++) checkOutput("b_flush_data", 32'(b_got[i]), 32'(8'h31 + i));
    if (b_dv_cyc.size() > 0) checkOutput("b_flush_latency", 32'(b_dv_cyc[0] - fcyc), 32'd0);
    checkOutput("b_flush_empty", 32'(b_empty), 32'd1);

    // Timeout: timer reaches 20 in cycle L+21, so tx_dv is high in cycle L+22
    b_got.delete(); b_dv_cyc.delete();
    for (int i = 0; i < 3; i++) stepB(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    lcyc = b_cyc;
    waitB(3);
    checkOutput("b_tmo_n_bytes", 32'(b_got.size()), 32'd3);
    for (int i = 0; i < 3 && i < b_got.size(); i++) checkOutput("b_tmo_data", 32'(b_got[i]), 32'(8'h41 + i));
    if (b_dv_cyc.size() > 0) checkOutput("b_tmo_latency", 32'(b_dv_cyc[0] - lcyc), 32'd21);
    checkOutput("b_tmo_empty", 32'(b_empty), 32'd1);
    checkOutput("b_no_overflow", 32'(b_overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_bridge.md
# uart_tx_fifo_bridge

Parametrised buffering bridge between a byte producer (glitcher control/status path) and the UART transmitter. It stores up to DEPTH words in a circular FIFO and issues them one at a time to the UART TX with a strict pulse/done handshake. It can either stream immediately or hold data until a burst threshold, an explicit flush, or an idle timeout is reached. Overflow and occupancy are reported.

## Interface
- DATA_W, 8: word width, matching the UART TX byte width.
- DEPTH, 16: FIFO depth; power of two, minimum 2.
- BURST_THRESH, 1: occupancy that starts a drain. 1 = stream mode; range 1..DEPTH.
- IDLE_TIMEOUT, 0: cycles without a write before a non-empty FIFO drains below threshold. 0 = disabled.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- in_dv  in  1  write strobe, one word per cycle.
- in_byte  in  DATA_W  write data.
- flush  in  1  level; forces drain while FIFO is non-empty.
- tx_busy  in  1  UART TX busy.
- tx_done  in  1  one-cycle pulse from UART TX when a byte has finished.
- tx_dv  out  1  one-cycle send pulse to UART TX.
- tx_byte  out  DATA_W  data to UART TX; stable from tx_dv until the next tx_dv.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when a write is dropped, cleared only by rst.

## Operation
- Storage is a DEPTH-entry array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- **Write acceptance:** a write is accepted when in_dv && (!full || pop), where pop is the issue event below.
  - An accepted write stores in_byte at wr_ptr and increments wr_ptr.
  - A write that is not accepted is dropped and sets overflow.
- **Drain latch (`draining`):**
  - Set when count >= BURST_THRESH, when flush is high, or when the idle timer expires.
  - Cleared when count reaches 0 after a pop.
- **Idle timer:**
  - Reloads to 0 on every accepted write and whenever the FIFO is empty.
  - Otherwise increments, saturating.
  - Expiry occurs when the timer reaches IDLE_TIMEOUT (only when IDLE_TIMEOUT != 0).
- **State machine:** two states, IDLE and WAIT_DONE.
  - IDLE: when draining && !empty && !tx_busy, this is the pop event. It registers tx_byte <= mem[rd_ptr], pulses tx_dv = 1 for one cycle, increments rd_ptr, decrements count, and moves to WAIT_DONE.
  - WAIT_DONE: on tx_done, return to IDLE. No tx_dv is issued in this state.
- **count on the same cycle as a write:**
  - Simultaneous accepted write and pop: count unchanged.
  - Write only: count + 1.
  - Pop only: count − 1.
- A tx_done seen in IDLE is ignored.
- **Reset values:**
  - tx_dv = 0, tx_byte = 0, count = 0.
  - empty = 1, full = 0, overflow = 0.
  - Pointers = 0, draining = 0, timer = 0, state = IDLE.
  - Memory contents are don't-care.
- Reset asserted mid-transfer discards all stored data and returns to IDLE. A tx_done arriving after reset is ignored.

## Timing
- Write at cycle N: count and empty update at cycle N+1.
- Stream mode with UART idle: the earliest tx_dv is high in cycle N+2, carrying that byte.
- Back-to-back bytes: the next tx_dv comes no earlier than 1 cycle after tx_done, provided tx_busy is low.
- full, empty and count are registered with count, so there is no combinational path from in_dv.
- flush takes effect at the next edge. If flush is held while writes continue, the FIFO keeps draining.
- A write during a full FIFO is accepted only in the exact cycle of a pop.

## Test plan
- **Stream:** BURST_THRESH=1; write 0xA5, with a UART model that takes 10 cycles from tx_dv to tx_done.
  - Required: tx_dv high exactly at N+2 with tx_byte = 0xA5.
  - Required: count returns 0 and empty = 1.
- **Ordering and wrap:** DEPTH=4; write 0x01..0x04, drain, then write 0x05..0x08, drain.
  - Required: UART receives 0x01..0x08 in order.
  - Required: pointers wrap and no overflow occurs.
- **Overflow:** DEPTH=4, UART busy; write 5 words 0x10..0x14.
  - Required: full = 1 after the 4th write and overflow = 1 after the 5th.
  - Required: the drained data is 0x10..0x13; 0x14 is lost.
- **Burst, flush and timeout:**
  - BURST_THRESH=4, write 3 words: no tx_dv.
  - Then assert flush for 1 cycle: all 3 words are sent.
  - Repeat with IDLE_TIMEOUT=20 and no flush: the drain starts 20 cycles after the last write.
- **Simultaneous write/pop when full:** DEPTH=4, full FIFO, in_dv in the pop cycle.
  - Required: the write is accepted, count stays 4 and overflow stays 0.
- **Reset mid-operation:** assert rst while in WAIT_DONE with 3 words queued.
  - Required: next cycle count = 0, empty = 1, tx_dv = 0.
  - Required: a subsequent tx_done causes no tx_dv.
